gshare_tagged_table: RTL and testbench
======================================

Name: gshare_tagged_table

Overview:
- Second-generation tagged gshare base-predictor table for the branch-predictor front end.
- Generalises the first-generation gshare in three ways:
  - counter, tag and history widths are parametrised;
  - query response is registered, and update is driven by carried-back metadata (index and tag) instead of a PC search buffer;
  - entries carry a usefulness field that gates replacement.
- The table is cleared by an init-sweep FSM, because reset cannot clear a large array in one cycle.

Parameters:
- PC_WIDTH, 32, instruction address width.
- GHR_LENGTH, 16, global history bits consumed.
- INDEX_WIDTH, 10, log2 of table depth.
- TAG_WIDTH, 8, stored partial tag width.
- CTR_WIDTH, 3, saturating direction counter width (≥2).
- USEFUL_WIDTH, 2, usefulness counter width (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- query_valid_i  in  1  lookup request
- query_pc_i  in  PC_WIDTH  branch PC
- global_history_i  in  GHR_LENGTH  speculative global history
- query_ready_o  out  1  table ready (low during init sweep)
- resp_valid_o  out  1  response valid, one cycle after an accepted query
- resp_taken_o  out  1  MSB of stored counter
- resp_tag_hit_o  out  1  stored tag equals query tag
- resp_ctr_o  out  CTR_WIDTH  raw counter value
- resp_meta_o  out  INDEX_WIDTH+TAG_WIDTH  {index, tag} carried to update
- update_valid_i  in  1  commit-time update
- update_meta_i  in  INDEX_WIDTH+TAG_WIDTH  meta returned from resp_meta_o
- update_taken_i  in  1  resolved direction
- update_correct_i  in  1  this table's prediction was correct
- init_busy_o  out  1  sweep in progress

Behaviour:
- Entry layout: {tag[TAG_WIDTH], ctr[CTR_WIDTH], useful[USEFUL_WIDTH]}.
- Fold(x, N): XOR of consecutive N-bit slices of x, LSB first; the last slice is zero-padded.
- Query index = fold(global_history_i, INDEX_WIDTH) XOR query_pc_i[2 +: INDEX_WIDTH].
- Query tag = fold(query_pc_i[PC_WIDTH-1:2], TAG_WIDTH).
- Weak-taken value (WT) = 1 followed by CTR_WIDTH-1 zeros. Weak-not-taken value (WNT) = 0 followed by ones.
- FSM states: INIT and READY.
  - rst (any cycle, including mid-sweep) forces INIT with the sweep pointer at 0.
  - In INIT, each cycle writes entry[ptr] = {0, WT, 0} and increments ptr.
  - On the cycle ptr = 2^INDEX_WIDTH-1 is written, the next state is READY.
  - Sweep time is exactly 2^INDEX_WIDTH cycles after rst deasserts.
- In INIT: query_ready_o=0, init_busy_o=1. Queries are ignored (no resp_valid_o) and updates are dropped.
- Reset values: resp_valid_o=0, resp_taken_o=0, resp_tag_hit_o=0, resp_ctr_o=0, resp_meta_o=0, query_ready_o=0, init_busy_o=1.
- Query (READY):
  - Latency is 1 cycle. resp_* are registered.
  - resp_valid_o = query_valid_i delayed by one cycle. Other resp_* hold their value when resp_valid_o=0.
- Update (READY): read-modify-write in one cycle on entry[meta.index].
  - Tag match:
    - ctr saturating ±1 by update_taken_i; no wrap at 0 or all-ones.
    - useful saturating +1 if update_correct_i, else saturating -1.
  - Tag mismatch, useful==0: replace the entry with {meta.tag, taken?WT:WNT, 0}.
  - Tag mismatch, useful≠0: useful -1 (aging); tag and ctr unchanged.
- Simultaneous query and update to the same index: the response reflects the post-update entry (write-first bypass).
- Simultaneous query and update to different indices: independent.
- update_meta_i is used verbatim; no PC is needed at commit.

Decomposition:
- Shared package bpu_pkg holds:
  - entry struct;
  - meta struct (index, tag);
  - WT and WNT constant functions;
  - saturating inc/dec function parameterised on width.
- One sub-module: bpu_fold (parameters IN_WIDTH, OUT_WIDTH; combinational XOR-fold). Instantiated twice, for index and tag.

Test Plan:
- Reset/sweep, with defaults: rst high 1 cycle, then low.
  - init_busy_o=1 and query_ready_o=0 for exactly 1024 cycles, then 1/0 swap.
  - A subsequent query of any PC returns ctr=3'b100, resp_taken_o=1, resp_tag_hit_o=0 if the tag is nonzero.
- Rst mid-sweep: assert rst at sweep cycle 500.
  - The sweep restarts; READY arrives 1024 cycles after release.
  - An update issued during INIT is dropped (entry still {0,100,0}).
- Allocate then train, PC=0x1C000040, GHR=0:
  - update taken with mismatching tag: entry becomes {tag, 100, 00}.
  - Two more taken/correct updates: ctr 110, useful 10.
  - Query gives taken=1, tag_hit=1, one cycle after the query.
- Saturation: six taken updates on a matching entry give ctr=111 and it stays there; eight not-taken updates give ctr=000 and it stays there.
- Useful gating: entry with useful=2 and update with a foreign tag.
  - First update: useful 1, tag unchanged.
  - Second update: useful 0.
  - Third update: tag replaced, ctr=011 when taken=0.
- Bypass: a query and an update to the same index in the same cycle; the response shows the updated ctr. A query to a different index is unaffected.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared branch-predictor types and helpers: FSM state, default-width entry/meta
// layouts, counter constants and saturating arithmetic usable at any width up to MAXW.
package bpu_pkg;

    localparam int MAXW         = 16;
    localparam int DEF_INDEX_W  = 10;
    localparam int DEF_TAG_W    = 8;
    localparam int DEF_CTR_W    = 3;
    localparam int DEF_USEFUL_W = 2;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEF_TAG_W-1:0]    tag;
        logic [DEF_CTR_W-1:0]    ctr;
        logic [DEF_USEFUL_W-1:0] useful;
    } entry_t;

    typedef struct packed {
        logic [DEF_INDEX_W-1:0] index;
        logic [DEF_TAG_W-1:0]   tag;
    } meta_t;

    // Weak-taken: MSB set, rest clear.
    function automatic logic [MAXW-1:0] wt_val(input int unsigned w);
        return 16'd1 << (w - 1);
    endfunction

    // Weak-not-taken: MSB clear, rest set.
    function automatic logic [MAXW-1:0] wnt_val(input int unsigned w);
        return (16'd1 << (w - 1)) - 16'd1;
    endfunction

    function automatic logic [MAXW-1:0] sat_inc(input logic [MAXW-1:0] v, input int unsigned w);
        logic [MAXW-1:0] max_v;
        max_v = (w >= MAXW) ? 16'hFFFF : ((16'd1 << w) - 16'd1);
        return (v == max_v) ? v : (v + 16'd1);
    endfunction

    function automatic logic [MAXW-1:0] sat_dec(input logic [MAXW-1:0] v, input int unsigned w);
        logic [MAXW-1:0] unused_w;
        unused_w = MAXW'(w);
        return (v == 16'd0) ? v : (v - 16'd1);
    endfunction

endpackage

// File: rtl/bpu_fold.sv
// Combinational XOR-fold: XORs consecutive OUT_WIDTH slices of the input, LSB
// first, with the last slice zero-padded.
module bpu_fold #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 10
) (
    input  logic [IN_WIDTH-1:0]  value,
    output logic [OUT_WIDTH-1:0] folded
);

    localparam int SLICES    = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int PAD_WIDTH = SLICES * OUT_WIDTH;

    logic [PAD_WIDTH-1:0] padded_s;
    assign padded_s = PAD_WIDTH'(value);

    // XOR-reduce all slices of the padded input.
    always_comb begin
        folded = '0;
        for (int s = 0; s < SLICES; s++) begin
            folded = folded ^ padded_s[s*OUT_WIDTH +: OUT_WIDTH];
        end
    end

endmodule

// File: rtl/gshare_tagged_table.sv
// Tagged gshare base-predictor table: registered lookup, metadata-driven update
// with usefulness-gated replacement, and an init sweep that clears the array.
module gshare_tagged_table
    import bpu_pkg::*;
#(
    parameter int PC_WIDTH     = 32,
    parameter int GHR_LENGTH   = 16,
    parameter int INDEX_WIDTH  = DEF_INDEX_W,
    parameter int TAG_WIDTH    = DEF_TAG_W,
    parameter int CTR_WIDTH    = DEF_CTR_W,
    parameter int USEFUL_WIDTH = DEF_USEFUL_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            query_valid_i,
    input  logic [PC_WIDTH-1:0]             query_pc_i,
    input  logic [GHR_LENGTH-1:0]           global_history_i,
    output logic                            query_ready_o,
    output logic                            resp_valid_o,
    output logic                            resp_taken_o,
    output logic                            resp_tag_hit_o,
    output logic [CTR_WIDTH-1:0]            resp_ctr_o,
    output logic [INDEX_WIDTH+TAG_WIDTH-1:0] resp_meta_o,
    input  logic                            update_valid_i,
    input  logic [INDEX_WIDTH+TAG_WIDTH-1:0] update_meta_i,
    input  logic                            update_taken_i,
    input  logic                            update_correct_i,
    output logic                            init_busy_o
);

    localparam int DEPTH = 1 << INDEX_WIDTH;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]    tag;
        logic [CTR_WIDTH-1:0]    ctr;
        logic [USEFUL_WIDTH-1:0] useful;
    } tbl_entry_t;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] index;
        logic [TAG_WIDTH-1:0]   tag;
    } tbl_meta_t;

    localparam logic [CTR_WIDTH-1:0] CTR_WT  = CTR_WIDTH'(wt_val(CTR_WIDTH));
    localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WIDTH'(wnt_val(CTR_WIDTH));

    tbl_entry_t entries_mem [DEPTH];

    state_t                 state_r;
    state_t                 state_next_s;
    logic [INDEX_WIDTH-1:0] ptr_r;
    logic                   busy_next_s;
    logic                   ready_next_s;
    logic                   init_busy_r;
    logic                   query_ready_r;

    logic [INDEX_WIDTH-1:0] ghr_fold_s;
    logic [TAG_WIDTH-1:0]   q_tag_s;
    logic [INDEX_WIDTH-1:0] q_index_s;
    logic                   q_fire_s;
    tbl_entry_t             q_entry_s;

    tbl_meta_t              upd_meta_s;
    tbl_entry_t             upd_cur_s;
    tbl_entry_t             upd_new_s;
    logic                   upd_fire_s;

    logic                   mem_we_s;
    logic [INDEX_WIDTH-1:0] mem_waddr_s;
    tbl_entry_t             mem_wdata_s;

    logic                   resp_valid_r;
    logic                   resp_taken_r;
    logic                   resp_tag_hit_r;
    logic [CTR_WIDTH-1:0]   resp_ctr_r;
    logic [INDEX_WIDTH+TAG_WIDTH-1:0] resp_meta_r;

    logic                   unused_pc_lo;
    assign unused_pc_lo = ^query_pc_i[1:0];

    bpu_fold #(.IN_WIDTH(GHR_LENGTH), .OUT_WIDTH(INDEX_WIDTH)) u_fold_index (
        .value  (global_history_i),
        .folded (ghr_fold_s)
    );

    bpu_fold #(.IN_WIDTH(PC_WIDTH-2), .OUT_WIDTH(TAG_WIDTH)) u_fold_tag (
        .value  (query_pc_i[PC_WIDTH-1:2]),
        .folded (q_tag_s)
    );

    assign q_index_s = ghr_fold_s ^ query_pc_i[2 +: INDEX_WIDTH];

    // FSM state register and sweep pointer; rst restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_INIT;
            ptr_r   <= '0;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_INIT) begin
                ptr_r <= ptr_r + {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                ptr_r <= '0;
            end
        end
    end

    // Next-state logic: leave INIT on the cycle the last entry is written.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT:  state_next_s = (&ptr_r) ? ST_READY : ST_INIT;
            ST_READY: state_next_s = ST_READY;
            default:  state_next_s = ST_INIT;
        endcase
    end

    // Status outputs decoded from the next state so the registered copies track state_r.
    always_comb begin
        busy_next_s  = 1'b1;
        ready_next_s = 1'b0;
        case (state_next_s)
            ST_INIT: begin
                busy_next_s  = 1'b1;
                ready_next_s = 1'b0;
            end
            ST_READY: begin
                busy_next_s  = 1'b0;
                ready_next_s = 1'b1;
            end
            default: begin
                busy_next_s  = 1'b1;
                ready_next_s = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_busy_r   <= 1'b1;
            query_ready_r <= 1'b0;
        end else begin
            init_busy_r   <= busy_next_s;
            query_ready_r <= ready_next_s;
        end
    end

    assign upd_meta_s = tbl_meta_t'(update_meta_i);
    assign upd_cur_s  = entries_mem[upd_meta_s.index];
    assign upd_fire_s = update_valid_i && (state_r == ST_READY) && !rst;
    assign q_fire_s   = query_valid_i && (state_r == ST_READY);

    // Update read-modify-write: train on tag match, else age or replace by usefulness.
    always_comb begin
        upd_new_s = upd_cur_s;
        if (upd_cur_s.tag == upd_meta_s.tag) begin
            upd_new_s.ctr = update_taken_i
                ? CTR_WIDTH'(sat_inc(MAXW'(upd_cur_s.ctr), CTR_WIDTH))
                : CTR_WIDTH'(sat_dec(MAXW'(upd_cur_s.ctr), CTR_WIDTH));
            upd_new_s.useful = update_correct_i
                ? USEFUL_WIDTH'(sat_inc(MAXW'(upd_cur_s.useful), USEFUL_WIDTH))
                : USEFUL_WIDTH'(sat_dec(MAXW'(upd_cur_s.useful), USEFUL_WIDTH));
        end else if (upd_cur_s.useful == '0) begin
            upd_new_s.tag    = upd_meta_s.tag;
            upd_new_s.ctr    = update_taken_i ? CTR_WT : CTR_WNT;
            upd_new_s.useful = '0;
        end else begin
            upd_new_s.useful = USEFUL_WIDTH'(sat_dec(MAXW'(upd_cur_s.useful), USEFUL_WIDTH));
        end
    end

    // Single write port shared by the init sweep and commit updates.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = ptr_r;
        mem_wdata_s = '{tag: '0, ctr: CTR_WT, useful: '0};
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_INIT) begin
            mem_we_s = 1'b1;
        end else if (upd_fire_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = upd_meta_s.index;
            mem_wdata_s = upd_new_s;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Table storage; cleared by the sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            entries_mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Lookup read with write-first bypass from a same-cycle update.
    always_comb begin
        if (upd_fire_s && (upd_meta_s.index == q_index_s)) begin
            q_entry_s = upd_new_s;
        end else begin
            q_entry_s = entries_mem[q_index_s];
        end
    end

    // Response registers; payload holds while no query is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r   <= 1'b0;
            resp_taken_r   <= 1'b0;
            resp_tag_hit_r <= 1'b0;
            resp_ctr_r     <= '0;
            resp_meta_r    <= '0;
        end else begin
            resp_valid_r <= q_fire_s;
            if (q_fire_s) begin
                resp_taken_r   <= q_entry_s.ctr[CTR_WIDTH-1];
                resp_tag_hit_r <= (q_entry_s.tag == q_tag_s);
                resp_ctr_r     <= q_entry_s.ctr;
                resp_meta_r    <= {q_index_s, q_tag_s};
            end
        end
    end

    assign query_ready_o  = query_ready_r;
    assign init_busy_o    = init_busy_r;
    assign resp_valid_o   = resp_valid_r;
    assign resp_taken_o   = resp_taken_r;
    assign resp_tag_hit_o = resp_tag_hit_r;
    assign resp_ctr_o     = resp_ctr_r;
    assign resp_meta_o    = resp_meta_r;

endmodule

// File: tb/tb_gshare_tagged_table.sv
// Directed bench for gshare_tagged_table: sweep timing, fold/meta vectors,
// allocate/train, saturation, usefulness gating and same-cycle bypass.
module tb_gshare_tagged_table;

    logic        clk;
    logic        rst;
    logic        query_valid_i;
    logic [31:0] query_pc_i;
    logic [15:0] global_history_i;
    logic        query_ready_o;
    logic        resp_valid_o;
    logic        resp_taken_o;
    logic        resp_tag_hit_o;
    logic [2:0]  resp_ctr_o;
    logic [17:0] resp_meta_o;
    logic        update_valid_i;
    logic [17:0] update_meta_i;
    logic        update_taken_i;
    logic        update_correct_i;
    logic        init_busy_o;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cnt;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] ghr;
        logic [17:0] meta;
    } qvec_t;

    qvec_t vecs [5];

    localparam logic [31:0] PC1   = 32'h1C00_0040;
    localparam logic [17:0] META1 = 18'h01017;
    localparam logic [31:0] PC2   = 32'h0000_0004;
    localparam logic [17:0] META2 = 18'h00101;
    localparam logic [17:0] FOREIGN1 = 18'h01055;

    gshare_tagged_table dut (
        .clk              (clk),
        .rst              (rst),
        .query_valid_i    (query_valid_i),
        .query_pc_i       (query_pc_i),
        .global_history_i (global_history_i),
        .query_ready_o    (query_ready_o),
        .resp_valid_o     (resp_valid_o),
        .resp_taken_o     (resp_taken_o),
        .resp_tag_hit_o   (resp_tag_hit_o),
        .resp_ctr_o       (resp_ctr_o),
        .resp_meta_o      (resp_meta_o),
        .update_valid_i   (update_valid_i),
        .update_meta_i    (update_meta_i),
        .update_taken_i   (update_taken_i),
        .update_correct_i (update_correct_i),
        .init_busy_o      (init_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic query(input logic [31:0] pc, input logic [15:0] ghr);
        query_valid_i    = 1'b1;
        query_pc_i       = pc;
        global_history_i = ghr;
        step();
        query_valid_i    = 1'b0;
    endtask

    task automatic update(input logic [17:0] meta, input logic taken, input logic correct);
        update_valid_i   = 1'b1;
        update_meta_i    = meta;
        update_taken_i   = taken;
        update_correct_i = correct;
        step();
        update_valid_i   = 1'b0;
    endtask

    task automatic chk_resp(input string name, input logic [2:0] ctr, input logic hit);
        chk({name, "_valid"}, 32'(resp_valid_o), 32'd1);
        chk({name, "_ctr"},   32'(resp_ctr_o),   32'(ctr));
        chk({name, "_taken"}, 32'(resp_taken_o), 32'(ctr[2]));
        chk({name, "_hit"},   32'(resp_tag_hit_o), 32'(hit));
    endtask

    initial begin
        vecs[0] = '{pc: 32'h1C00_0040, ghr: 16'h0000, meta: 18'h01017};
        vecs[1] = '{pc: 32'h0000_0004, ghr: 16'h0000, meta: 18'h00101};
        vecs[2] = '{pc: 32'h0000_1000, ghr: 16'hFC00, meta: 18'h03F04};
        vecs[3] = '{pc: 32'hFFFF_FFFC, ghr: 16'hFFFF, meta: 18'h03FC0};
        vecs[4] = '{pc: 32'h1234_5678, ghr: 16'h0155, meta: 18'h0CB02};

        rst = 1'b1;
        query_valid_i = 1'b0; query_pc_i = 32'd0; global_history_i = 16'd0;
        update_valid_i = 1'b0; update_meta_i = 18'd0;
        update_taken_i = 1'b0; update_correct_i = 1'b0;
        step();
        chk("rst_busy",       32'(init_busy_o),    32'd1);
        chk("rst_ready",      32'(query_ready_o),  32'd0);
        chk("rst_resp_valid", 32'(resp_valid_o),   32'd0);
        chk("rst_resp_taken", 32'(resp_taken_o),   32'd0);
        chk("rst_resp_hit",   32'(resp_tag_hit_o), 32'd0);
        chk("rst_resp_ctr",   32'(resp_ctr_o),     32'd0);
        chk("rst_resp_meta",  32'(resp_meta_o),    32'd0);

        // Full sweep length.
        rst = 1'b0;
        cnt = 0;
        while (init_busy_o === 1'b1 && cnt < 3000) begin
            step();
            cnt++;
        end
        chk("sweep_len",   32'(cnt),           32'd1024);
        chk("sweep_ready", 32'(query_ready_o), 32'd1);

        // Fold/meta vectors against a freshly cleared table.
        for (int i = 0; i < 5; i++) begin
            query(vecs[i].pc, vecs[i].ghr);
            chk_resp($sformatf("vec%0d", i), 3'b100, 1'b0);
            chk($sformatf("vec%0d_meta", i), 32'(resp_meta_o), 32'(vecs[i].meta));
        end
        step();
        chk("hold_valid_low", 32'(resp_valid_o), 32'd0);
        chk("hold_meta",      32'(resp_meta_o),  32'(vecs[4].meta));
        chk("hold_ctr",       32'(resp_ctr_o),   32'd4);

        // Reset mid-sweep, with a query and an update issued while sweeping.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 500; i++) step();
        chk("mid_busy", 32'(init_busy_o), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cnt = 0;
        while (init_busy_o === 1'b1 && cnt < 3000) begin
            if (cnt == 100) begin
                query_valid_i = 1'b1; query_pc_i = PC1; global_history_i = 16'd0;
                update_valid_i = 1'b1; update_meta_i = META1;
                update_taken_i = 1'b1; update_correct_i = 1'b1;
            end else begin
                query_valid_i = 1'b0;
                update_valid_i = 1'b0;
            end
            step();
            cnt++;
            if (cnt == 101) chk("init_query_ignored", 32'(resp_valid_o), 32'd0);
        end
        query_valid_i = 1'b0;
        update_valid_i = 1'b0;
        chk("resweep_len",   32'(cnt),           32'd1024);
        chk("resweep_ready", 32'(query_ready_o), 32'd1);
        query(PC1, 16'd0);
        chk_resp("init_update_dropped", 3'b100, 1'b0);

        // Allocate then train.
        update(META1, 1'b1, 1'b0);
        query(PC1, 16'd0);
        chk_resp("alloc", 3'b100, 1'b1);
        update(META1, 1'b1, 1'b1);
        update(META1, 1'b1, 1'b1);
        query(PC1, 16'd0);
        chk_resp("train", 3'b110, 1'b1);

        // Usefulness gating (useful is 2 after training).
        update(FOREIGN1, 1'b0, 1'b0);
        query(PC1, 16'd0);
        chk_resp("age1", 3'b110, 1'b1);
        update(FOREIGN1, 1'b0, 1'b0);
        query(PC1, 16'd0);
        chk_resp("age2", 3'b110, 1'b1);
        update(FOREIGN1, 1'b0, 1'b0);
        query(PC1, 16'd0);
        chk_resp("replace", 3'b011, 1'b0);

        // Saturation on PC2's entry.
        update(META2, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) update(META2, 1'b1, 1'b1);
        query(PC2, 16'd0);
        chk_resp("sat_high", 3'b111, 1'b1);
        for (int i = 0; i < 8; i++) update(META2, 1'b0, 1'b0);
        query(PC2, 16'd0);
        chk_resp("sat_low", 3'b000, 1'b1);

        // Same-index bypass: response shows the post-update counter.
        query_valid_i = 1'b1; query_pc_i = PC2; global_history_i = 16'd0;
        update(META2, 1'b1, 1'b1);
        query_valid_i = 1'b0;
        chk_resp("bypass_same", 3'b001, 1'b1);
        // Different-index update alongside a query leaves the response untouched.
        query_valid_i = 1'b1; query_pc_i = PC1; global_history_i = 16'd0;
        update(META2, 1'b1, 1'b1);
        query_valid_i = 1'b0;
        chk_resp("bypass_other", 3'b011, 1'b0);
        query(PC2, 16'd0);
        chk_resp("bypass_after", 3'b010, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
